// File: rtl/data_ram_responder.sv
// data_ram_responder: data-port RAM fronted by an in-order store buffer
// that drains at a fixed rate, with youngest-entry load forwarding.
module data_ram_responder #(
   parameter int ADDR_W    = 10,
   parameter int DEPTH     = 4,
   parameter int DRAIN_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memWriteM,
   input  logic [31:0] data_ram_waddr,
   input  logic [31:0] data_ram_wdataM,
   output logic [31:0] data_ram_rdata,
   output logic        stall,
   output logic        busy,
   output logic        err
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int DW = $clog2(DRAIN_LAT) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [DW-1:0] DMAX = DW'(DRAIN_LAT - 1);

   logic [31:0]       mem_q [0:2**ADDR_W-1] = '{default: '0};
   logic [ADDR_W-1:0] idx_q [DEPTH];
   logic [31:0]       dat_q [DEPTH];
   logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DW-1:0]     drain_q, drain_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] idx;
   logic              full, push, pop, unused_hi;

   assign idx       = data_ram_waddr[ADDR_W+1:2];
   assign unused_hi = ^data_ram_waddr[31:ADDR_W+2];
   assign full      = count_q == FULL;
   assign push      = memWriteM & ~full;
   assign pop       = (count_q != '0) & (drain_q == DMAX);
   assign stall     = memWriteM & full;
   assign busy      = count_q != '0;
   assign err       = err_q;

   assign head_d  = pop ? head_q + PW'(1) : head_q;
   assign tail_d  = push ? tail_q + PW'(1) : tail_q;
   assign count_d = count_q + CW'(push) - CW'(pop);
   assign drain_d = (count_q == '0 || pop) ? '0 : drain_q + DW'(1);
   assign err_d   = err_q | (push & |data_ram_waddr[1:0]);

   // Scan oldest to youngest so the last match (youngest) wins over the array.
   always_comb begin
      data_ram_rdata = mem_q[idx];
      for (int k = 0; k < DEPTH; k++)
         if (CW'(k) < count_q && idx_q[head_q + PW'(k)] == idx)
            data_ram_rdata = dat_q[head_q + PW'(k)];
   end

   always_ff @(posedge clk) begin
      if (push) begin
         idx_q[tail_q] <= idx;
         dat_q[tail_q] <= data_ram_wdataM;
      end
      if (pop) mem_q[idx_q[head_q]] <= dat_q[head_q];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         drain_q <= '0;
         err_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         drain_q <= drain_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_data_ram_responder.sv
// tb_data_ram_responder: directed steps with hand-computed expectations
// for the store buffer, forwarding, stall, drain timing, err and reset.
module tb_data_ram_responder;
   logic        clk = 1'b0;
   logic        rst;
   logic        memWriteM;
   logic [31:0] data_ram_waddr;
   logic [31:0] data_ram_wdataM;
   logic [31:0] data_ram_rdata;
   logic        stall, busy, err;
   int checks = 0;
   int errors = 0;

   data_ram_responder dut (
      .clk(clk), .rst(rst), .memWriteM(memWriteM),
      .data_ram_waddr(data_ram_waddr), .data_ram_wdataM(data_ram_wdataM),
      .data_ram_rdata(data_ram_rdata), .stall(stall), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic st(input logic [31:0] a, input logic [31:0] d);
      memWriteM = 1'b1;
      data_ram_waddr = a;
      data_ram_wdataM = d;
   endtask

   task automatic ld(input logic [31:0] a);
      memWriteM = 1'b0;
      data_ram_waddr = a;
      #1;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 40 && busy !== 1'b0; i++) tick();
      chk(tag, {31'b0, busy}, 32'h0);
   endtask

   initial begin
      rst = 1'b0;
      memWriteM = 1'b0;
      data_ram_waddr = 32'h10;
      data_ram_wdataM = '0;
      #1;
      chk("rst_rdata", data_ram_rdata, 32'h0);
      chk("rst_stall", {31'b0, stall}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_err", {31'b0, err}, 32'h0);
      tick();
      tick();
      rst = 1'b1;
      tick();

      // single store, forwarding, drain after DRAIN_LAT edges
      st(32'h20, 32'hDEADBEEF);
      #1 chk("st1_stall", {31'b0, stall}, 32'h0);
      tick();
      ld(32'h20);
      chk("fwd_deadbeef", data_ram_rdata, 32'hDEADBEEF);
      chk("busy_after_accept", {31'b0, busy}, 32'h1);
      tick();
      chk("busy_t1", {31'b0, busy}, 32'h1);
      tick();
      chk("busy_t2", {31'b0, busy}, 32'h0);
      chk("arr_deadbeef", data_ram_rdata, 32'hDEADBEEF);

      // streaming stores until the buffer fills
      for (int k = 0; k < 6; k++) begin
         st(32'(k * 4), 32'hA000_0000 + 32'(k));
         tick();
      end
      st(32'h18, 32'hA000_0006);
      #1 chk("full_stall", {31'b0, stall}, 32'h1);
      chk("full_busy", {31'b0, busy}, 32'h1);
      tick();
      chk("stall_released", {31'b0, stall}, 32'h0);
      tick();
      ld(32'h14);
      chk("fwd_word14", data_ram_rdata, 32'hA000_0005);
      ld(32'h0);
      chk("arr_word0", data_ram_rdata, 32'hA000_0000);
      wait_idle("stream_drain");
      for (int k = 0; k < 7; k++) begin
         ld(32'(k * 4));
         chk($sformatf("readback_%0d", k), data_ram_rdata, 32'hA000_0000 + 32'(k));
      end

      // duplicate index: youngest wins, then last commit wins
      st(32'h40, 32'h11111111);
      tick();
      st(32'h40, 32'h22222222);
      tick();
      ld(32'h40);
      chk("dup_fwd", data_ram_rdata, 32'h22222222);
      tick();
      chk("dup_after_pop1", data_ram_rdata, 32'h22222222);
      wait_idle("dup_drain");
      chk("dup_arr", data_ram_rdata, 32'h22222222);

      // misaligned store
      st(32'h42, 32'hCAFEF00D);
      #1 chk("mis_err_before", {31'b0, err}, 32'h0);
      tick();
      ld(32'h40);
      chk("mis_err_set", {31'b0, err}, 32'h1);
      chk("mis_fwd", data_ram_rdata, 32'hCAFEF00D);
      repeat (20) tick();
      chk("mis_err_sticky", {31'b0, err}, 32'h1);
      chk("mis_arr", data_ram_rdata, 32'hCAFEF00D);
      chk("mis_idle", {31'b0, busy}, 32'h0);

      // address aliasing above ADDR_W+1
      ld(32'h0000_1020);
      chk("alias_20", data_ram_rdata, 32'hDEADBEEF);

      // reset in the middle of a drain
      st(32'h80, 32'h55555555);
      tick();
      st(32'h84, 32'h66666666);
      tick();
      st(32'h88, 32'h77777777);
      tick();
      memWriteM = 1'b0;
      #1 chk("pre_rst_busy", {31'b0, busy}, 32'h1);
      memWriteM = 1'b1;
      rst = 1'b0;
      #1;
      chk("mid_rst_busy", {31'b0, busy}, 32'h0);
      chk("mid_rst_stall", {31'b0, stall}, 32'h0);
      chk("mid_rst_err", {31'b0, err}, 32'h0);
      memWriteM = 1'b0;
      tick();
      rst = 1'b1;
      ld(32'h80);
      chk("rst_kept_80", data_ram_rdata, 32'h55555555);
      ld(32'h84);
      chk("rst_lost_84", data_ram_rdata, 32'h0);
      ld(32'h88);
      chk("rst_lost_88", data_ram_rdata, 32'h0);
      tick();
      chk("post_rst_busy", {31'b0, busy}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
